ifu: RTL and testbench

Instruction fetch unit for the ysyx_23060251 core. Owns the program counter, drives it to the instruction ROM, and registers the returned word into a single-entry output slot. The slot is handed to the decode stage over a valid/ready handshake. Handles redirects from execute, halts after fetching `ebreak`, and faults on misaligned PCs.

---
 rtl/ifu.sv | 113 +++++++++++
 tb/tb_ifu.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ifu.sv
`default_nettype none
// ============================================================================
// Module   : ifu
// Purpose  : Instruction fetch unit: PC owner, single-entry output slot with
//            valid/ready handoff to decode, redirect, ebreak halt, misalign fault.
// Revision : 1.0
// ============================================================================
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] EBREAK   = 32'h0010_0073
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    output logic [31:0] rom_pc_o,
    input  logic [31:0] rom_inst_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_inst_o,
    output logic [31:0] out_pc_o,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        halted_o,
    output logic        fault_o,
    output logic [31:0] fault_pc_o,
    output logic [31:0] fetch_cnt_o
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic        r_out_valid;
    logic        w_out_valid_nxt;
    logic [31:0] r_out_inst;
    logic [31:0] w_out_inst_nxt;
    logic [31:0] r_out_pc;
    logic [31:0] w_out_pc_nxt;
    logic [31:0] r_fault_pc;
    logic [31:0] w_fault_pc_nxt;
    logic [31:0] r_fetch_cnt;
    logic [31:0] w_fetch_cnt_nxt;
    logic        w_xfer;
    logic        w_slot_free;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= ST_RUN;
            r_pc        <= RESET_PC;
            r_out_valid <= 1'b0;
            r_out_inst  <= 32'h0;
            r_out_pc    <= 32'h0;
            r_fault_pc  <= 32'h0;
            r_fetch_cnt <= 32'h0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_inst  <= w_out_inst_nxt;
            r_out_pc    <= w_out_pc_nxt;
            r_fault_pc  <= w_fault_pc_nxt;
            r_fetch_cnt <= w_fetch_cnt_nxt;
        end
    end

    always_comb begin
        w_xfer          = r_out_valid & out_ready_i;
        w_slot_free     = ~r_out_valid | w_xfer;
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        // A consumed slot empties unless a new fetch refills it below.
        w_out_valid_nxt = r_out_valid & ~w_xfer;
        w_out_inst_nxt  = r_out_inst;
        w_out_pc_nxt    = r_out_pc;
        w_fault_pc_nxt  = r_fault_pc;
        w_fetch_cnt_nxt = r_fetch_cnt + {31'b0, w_xfer};

        if (redirect_valid_i) begin
            w_pc_nxt        = redirect_pc_i;
            w_out_valid_nxt = 1'b0;
            w_state_nxt     = ST_RUN;
        end else if (r_state == ST_RUN && w_slot_free) begin
            if (r_pc[1:0] != 2'b00) begin
                w_state_nxt    = ST_FAULT;
                w_fault_pc_nxt = r_pc;
            end else begin
                w_out_valid_nxt = 1'b1;
                w_out_inst_nxt  = rom_inst_i;
                w_out_pc_nxt    = r_pc;
                w_pc_nxt        = r_pc + 32'd4;
                if (rom_inst_i == EBREAK) begin
                    w_state_nxt = ST_HALT;
                end
            end
        end
    end

    assign rom_pc_o    = r_pc;
    assign out_valid_o = r_out_valid;
    assign out_inst_o  = r_out_inst;
    assign out_pc_o    = r_out_pc;
    assign halted_o    = (r_state == ST_HALT);
    assign fault_o     = (r_state == ST_FAULT);
    assign fault_pc_o  = r_fault_pc;
    assign fetch_cnt_o = r_fetch_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ifu.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifu
// Purpose  : Self-checking bench for ifu: directed scenarios plus random
//            ready/redirect traffic against a behavioural fetch model.
// Revision : 1.0
// ============================================================================
module tb_ifu;

    localparam logic [31:0] c_ebreak = 32'h0010_0073;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [31:0] rom_pc_o;
    logic [31:0] rom_inst_i;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] out_inst_o;
    logic [31:0] out_pc_o;
    logic        redirect_valid_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        halted_o;
    logic        fault_o;
    logic [31:0] fault_pc_o;
    logic [31:0] fetch_cnt_o;

    logic [31:0] mem [256];
    int total = 0;
    int bad   = 0;

    // Model state: mode 0 = running, 1 = halted, 2 = faulted
    int          m_mode;
    logic [31:0] m_pc, m_inst, m_opc, m_fpc, m_cnt;
    logic        m_valid;

    always #5 clk_i = ~clk_i;

    assign rom_inst_i = mem[rom_pc_o[9:2]];

    ifu #(.RESET_PC(32'h0), .EBREAK(c_ebreak)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .rom_pc_o(rom_pc_o), .rom_inst_i(rom_inst_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_inst_o(out_inst_o), .out_pc_o(out_pc_o),
        .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
        .halted_o(halted_o), .fault_o(fault_o), .fault_pc_o(fault_pc_o),
        .fetch_cnt_o(fetch_cnt_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pc = 32'h0; m_valid = 1'b0;
        m_inst = 32'h0; m_opc = 32'h0; m_fpc = 32'h0; m_cnt = 32'h0;
    endtask

    task automatic compare();
        chk("rom_pc",    rom_pc_o,            m_pc);
        chk("valid",     {31'b0, out_valid_o}, {31'b0, m_valid});
        chk("inst",      out_inst_o,          m_inst);
        chk("out_pc",    out_pc_o,            m_opc);
        chk("halted",    {31'b0, halted_o},   (m_mode == 1) ? 32'd1 : 32'd0);
        chk("fault",     {31'b0, fault_o},    (m_mode == 2) ? 32'd1 : 32'd0);
        chk("fault_pc",  fault_pc_o,          m_fpc);
        chk("fetch_cnt", fetch_cnt_o,         m_cnt);
    endtask

    // One clock: apply inputs, advance the model by the fetch rules, then compare.
    task automatic cyc(input logic rdy, input logic rv, input logic [31:0] rpc);
        logic taken;
        logic [31:0] word;
        out_ready_i = rdy; redirect_valid_i = rv; redirect_pc_i = rpc;
        taken = m_valid && rdy;
        word  = mem[m_pc[9:2]];
        if (taken) begin
            m_cnt   = m_cnt + 1;
            m_valid = 1'b0;
        end
        if (rv) begin
            m_pc = rpc; m_valid = 1'b0; m_mode = 0;
        end else if (m_mode == 0 && !m_valid) begin
            if (m_pc % 4 != 0) begin
                m_mode = 2; m_fpc = m_pc;
            end else begin
                m_valid = 1'b1; m_inst = word; m_opc = m_pc; m_pc = m_pc + 4;
                if (word == c_ebreak) m_mode = 1;
            end
        end
        @(posedge clk_i);
        #1;
        compare();
    endtask

    initial begin
        logic [31:0] rnd;
        for (int i = 0; i < 256; i++) begin
            rnd = $urandom;
            mem[i] = (rnd == c_ebreak) ? 32'h13 : rnd;
        end
        mem[0] = 32'h0000_0113; mem[1] = 32'h0040_0193;
        mem[2] = 32'h0081_8233; mem[3] = 32'hFFC2_0293;
        mem[4] = c_ebreak;
        mem[100] = c_ebreak; mem[200] = c_ebreak;
        model_reset();

        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_rom_pc", rom_pc_o, 32'h0);
        chk("rst_valid", {31'b0, out_valid_o}, 32'h0);
        chk("rst_cnt", fetch_cnt_o, 32'h0);
        #2 rst_n_i = 1'b1;

        // Stream from reset, then ebreak at 0x10
        cyc(1, 0, 0); chk("s_pc0", out_pc_o, 32'h0); chk("s_w0", out_inst_o, 32'h0000_0113);
        cyc(1, 0, 0); chk("s_pc4", out_pc_o, 32'h4);
        cyc(1, 0, 0); chk("s_pc8", out_pc_o, 32'h8);
        cyc(1, 0, 0); chk("s_pcC", out_pc_o, 32'hC); chk("s_w3", out_inst_o, 32'hFFC2_0293);
        cyc(1, 0, 0); chk("s_cnt4", fetch_cnt_o, 32'd4); chk("e_inst", out_inst_o, c_ebreak);
        chk("e_halt", {31'b0, halted_o}, 32'd1);
        cyc(1, 0, 0); chk("e_novalid", {31'b0, out_valid_o}, 32'd0);
        cyc(1, 0, 0); chk("e_frozen", rom_pc_o, 32'h14);
        cyc(1, 1, 32'h0); chk("e_resume", {31'b0, halted_o}, 32'd0);
        cyc(1, 0, 0); chk("e_pc0", out_pc_o, 32'h0);

        // Backpressure on the word at 0x4
        cyc(1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0);
            chk("bp_pc", out_pc_o, 32'h4); chk("bp_rom", rom_pc_o, 32'h8);
        end
        cyc(1, 0, 0); chk("bp_next", out_pc_o, 32'h8);

        // Redirect while stalled
        cyc(0, 1, 32'h40); chk("rd_squash", {31'b0, out_valid_o}, 32'd0);
        cyc(0, 0, 0); chk("rd_pc", out_pc_o, 32'h40); chk("rd_cnt", fetch_cnt_o, 32'd7);

        // Misaligned fetch and recovery
        cyc(0, 1, 32'h22);
        cyc(0, 0, 0); chk("mis_fault", {31'b0, fault_o}, 32'd1); chk("mis_fpc", fault_pc_o, 32'h22);
        cyc(0, 0, 0); chk("mis_hold", rom_pc_o, 32'h22);
        cyc(0, 1, 32'h24); chk("mis_clear", {31'b0, fault_o}, 32'd0);
        cyc(1, 0, 0); chk("mis_pc24", out_pc_o, 32'h24);

        // Redirect with a simultaneous transfer
        cyc(1, 1, 32'h80); chk("rx_cnt", fetch_cnt_o, 32'd8); chk("rx_squash", {31'b0, out_valid_o}, 32'd0);
        cyc(1, 0, 0); chk("rx_pc", out_pc_o, 32'h80);
        cyc(0, 0, 0);

        // Asynchronous reset between edges
        #2 rst_n_i = 1'b0;
        #1;
        model_reset();
        chk("ar_rom_pc", rom_pc_o, 32'h0);
        chk("ar_valid", {31'b0, out_valid_o}, 32'd0);
        chk("ar_cnt", fetch_cnt_o, 32'd0);
        chk("ar_pc", out_pc_o, 32'h0);
        compare();
        #3 rst_n_i = 1'b1;
        cyc(1, 0, 0); chk("ar_first", {31'b0, out_valid_o}, 32'd1);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            logic rdy, rv;
            logic [31:0] tgt;
            rdy = ($urandom % 10) < 7;
            rv  = ($urandom % 16) == 0;
            tgt = {22'b0, 8'($urandom), 2'b00};
            if ($urandom % 6 == 0) tgt[1:0] = 2'($urandom);
            cyc(rdy, rv, tgt);
            if (n == 1500) begin
                #2 rst_n_i = 1'b0;
                #1 model_reset();
                compare();
                #3 rst_n_i = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
